// File: rtl/sprite_line_scheduler_if.sv
// Bundle of the scheduler's control, OAM / sprite-graphics read ports and slot-load bus.
// master = scheduler side, slave = PPU / memories / shift-register side.
interface sprite_line_scheduler_if;
    logic        line_start;
    logic [7:0]  next_line;
    logic [7:0]  oam_addr;
    logic [31:0] oam_rdata;
    logic [10:0] gfx_addr;
    logic [31:0] gfx_rdata;
    logic        load_valid;
    logic [2:0]  load_slot;
    logic [31:0] load_data;
    logic [8:0]  load_x;
    logic        load_pal;
    logic        busy;
    logic        done;
    logic        overflow;

    modport master (
        input  line_start, next_line, oam_rdata, gfx_rdata,
        output oam_addr, gfx_addr, load_valid, load_slot, load_data,
               load_x, load_pal, busy, done, overflow
    );

    modport slave (
        output line_start, next_line, oam_rdata, gfx_rdata,
        input  oam_addr, gfx_addr, load_valid, load_slot, load_data,
               load_x, load_pal, busy, done, overflow
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans OAM for sprites covering next_line, then
// fetches one graphics row per slot and streams MAX_SLOTS loads to the shift registers.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 64,
    parameter int MAX_SLOTS   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    sprite_line_scheduler_if.master bus
);
    localparam int SW = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_SLOTS);
    localparam logic [SW-1:0] LAST_SLOT  = SW'(MAX_SLOTS - 1);
    localparam logic [7:0]    LAST_ENTRY = 8'(NUM_SPRITES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]    state_reg;
    logic [7:0]    line_reg;
    logic [7:0]    oam_addr_reg;
    logic          rd_valid_reg;
    logic [7:0]    rd_idx_reg;
    logic [CW-1:0] hit_count_reg;
    logic [SW-1:0] fetch_slot_reg;
    logic [10:0]   gfx_addr_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          overflow_reg;

    logic          pend_valid_reg;
    logic          pend_real_reg;
    logic [SW-1:0] pend_slot_reg;
    logic [8:0]    pend_x_reg;
    logic          pend_pal_reg;

    logic          load_valid_reg;
    logic          load_real_reg;
    logic [SW-1:0] load_slot_reg;
    logic [8:0]    load_x_reg;
    logic          load_pal_reg;

    logic [8:0]    hit_x   [MAX_SLOTS];
    logic [10:0]   hit_gfx [MAX_SLOTS];
    logic          hit_pal [MAX_SLOTS];

    // Decode of the OAM word currently on oam_rdata
    logic [8:0] ent_x;
    logic [7:0] ent_y;
    logic [6:0] ent_tile;
    logic       ent_vflip;
    logic       ent_pal;
    logic [7:0] diff;
    logic [3:0] ent_row;
    logic       ent_hit;
    logic       list_full;
    logic       append;
    logic       slot_is_real;

    assign ent_x     = bus.oam_rdata[8:0];
    assign ent_y     = bus.oam_rdata[16:9];
    assign ent_tile  = bus.oam_rdata[23:17];
    assign ent_vflip = bus.oam_rdata[24];
    assign ent_pal   = bus.oam_rdata[25];

    // Modulo-256 difference lets sprites near y=255 wrap onto the top lines
    assign diff      = line_reg - ent_y;
    assign ent_hit   = (diff[7:4] == 4'd0);
    assign ent_row   = ent_vflip ? ~diff[3:0] : diff[3:0];
    assign list_full = (hit_count_reg == FULL_COUNT);
    assign append    = (state_reg == S_SCAN) && rd_valid_reg && ent_hit && !list_full
                       && !bus.line_start;
    assign slot_is_real = ({1'b0, fetch_slot_reg} < hit_count_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                hit_x[i]   <= '0;
                hit_gfx[i] <= '0;
                hit_pal[i] <= 1'b0;
            end
        end else if (append) begin
            hit_x[hit_count_reg[SW-1:0]]   <= ent_x;
            hit_gfx[hit_count_reg[SW-1:0]] <= {ent_tile, ent_row};
            hit_pal[hit_count_reg[SW-1:0]] <= ent_pal;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            line_reg       <= '0;
            oam_addr_reg   <= '0;
            rd_valid_reg   <= 1'b0;
            rd_idx_reg     <= '0;
            hit_count_reg  <= '0;
            fetch_slot_reg <= '0;
            gfx_addr_reg   <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_real_reg  <= 1'b0;
            pend_slot_reg  <= '0;
            pend_x_reg     <= '0;
            pend_pal_reg   <= 1'b0;
            load_valid_reg <= 1'b0;
            load_real_reg  <= 1'b0;
            load_slot_reg  <= '0;
            load_x_reg     <= '0;
            load_pal_reg   <= 1'b0;
        end else begin
            done_reg       <= 1'b0;
            pend_valid_reg <= 1'b0;

            // Load stage lines up with gfx_rdata, one cycle after the address went out
            load_valid_reg <= pend_valid_reg;
            load_real_reg  <= pend_valid_reg && pend_real_reg;
            if (pend_valid_reg) begin
                load_slot_reg <= pend_slot_reg;
                load_x_reg    <= pend_x_reg;
                load_pal_reg  <= pend_pal_reg;
            end

            if (bus.line_start) begin
                // Start, or abort-and-restart when already busy
                state_reg     <= S_SCAN;
                line_reg      <= bus.next_line;
                hit_count_reg <= '0;
                overflow_reg  <= 1'b0;
                busy_reg      <= 1'b1;
                oam_addr_reg  <= '0;
                rd_valid_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    S_SCAN: begin
                        rd_valid_reg <= 1'b1;
                        rd_idx_reg   <= oam_addr_reg;
                        if (oam_addr_reg != LAST_ENTRY) begin
                            oam_addr_reg <= oam_addr_reg + 8'd1;
                        end
                        if (rd_valid_reg) begin
                            if (ent_hit && list_full) begin
                                overflow_reg   <= 1'b1;
                                state_reg      <= S_FETCH;
                                fetch_slot_reg <= '0;
                            end else begin
                                if (ent_hit) begin
                                    hit_count_reg <= hit_count_reg + CW'(1);
                                end
                                if (rd_idx_reg == LAST_ENTRY) begin
                                    state_reg      <= S_FETCH;
                                    fetch_slot_reg <= '0;
                                end
                            end
                        end
                    end
                    S_FETCH: begin
                        pend_valid_reg <= 1'b1;
                        pend_slot_reg  <= fetch_slot_reg;
                        pend_real_reg  <= slot_is_real;
                        if (slot_is_real) begin
                            gfx_addr_reg <= hit_gfx[fetch_slot_reg];
                            pend_x_reg   <= hit_x[fetch_slot_reg];
                            pend_pal_reg <= hit_pal[fetch_slot_reg];
                        end else begin
                            pend_x_reg   <= '0;
                            pend_pal_reg <= 1'b0;
                        end
                        if (fetch_slot_reg == LAST_SLOT) begin
                            state_reg <= S_DRAIN;
                        end else begin
                            fetch_slot_reg <= fetch_slot_reg + SW'(1);
                        end
                    end
                    S_DRAIN: begin
                        state_reg <= S_FINISH;
                    end
                    S_FINISH: begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.oam_addr   = oam_addr_reg;
    assign bus.gfx_addr   = gfx_addr_reg;
    assign bus.load_valid = load_valid_reg;
    assign bus.load_slot  = 3'(load_slot_reg);
    assign bus.load_data  = load_real_reg ? bus.gfx_rdata : 32'd0;
    assign bus.load_x     = load_x_reg;
    assign bus.load_pal   = load_pal_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: OAM and graphics memory models with
// one-cycle read latency, a load/done monitor, and one task per scenario.
module tb_sprite_line_scheduler;
    logic clk;
    logic reset;

    sprite_line_scheduler_if bus ();

    sprite_line_scheduler #(
        .NUM_SPRITES(64),
        .MAX_SLOTS  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] oam_mem [64];
    int cyc;
    int checks;
    int passed;
    int load_cnt;
    int done_cnt;
    int done_cyc;
    int last_load_cyc;
    int start_cyc;
    logic [31:0] cap_data  [8];
    logic [8:0]  cap_x     [8];
    logic        cap_pal   [8];
    logic [2:0]  cap_order [16];

    function automatic logic [31:0] gfx_val(input logic [10:0] a);
        return 32'h5A00_0000 ^ {5'd0, a, 5'd0, a};
    endfunction

    function automatic logic [31:0] make_ent(input logic [8:0] x, input logic [7:0] y,
                                             input logic [6:0] tile, input logic vflip,
                                             input logic pal);
        return {6'd0, pal, vflip, tile, y, x};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        bus.oam_rdata <= oam_mem[bus.oam_addr[5:0]];
        bus.gfx_rdata <= gfx_val(bus.gfx_addr);
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.load_valid === 1'b1) begin
                if (load_cnt < 16) cap_order[load_cnt] = bus.load_slot;
                cap_data[bus.load_slot] = bus.load_data;
                cap_x[bus.load_slot]    = bus.load_x;
                cap_pal[bus.load_slot]  = bus.load_pal;
                last_load_cyc = cyc;
                load_cnt++;
                $display("load  slot=%0d data=%08h x=%0d pal=%0d cyc=%0d",
                         bus.load_slot, bus.load_data, bus.load_x, bus.load_pal, cyc);
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                $display("done  cyc=%0d overflow=%0d", cyc, bus.overflow);
            end
        end
    end

    task automatic clear_oam();
        for (int i = 0; i < 64; i++) oam_mem[i] = make_ent(9'd0, 8'd200, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic clear_capture();
        load_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cap_data[i] = 32'hDEAD_BEEF;
            cap_x[i]    = 9'h1FF;
            cap_pal[i]  = 1'b1;
        end
    endtask

    task automatic start_line(input logic [7:0] nl);
        @(posedge clk);
        #1;
        bus.next_line  = nl;
        bus.line_start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc      = cyc;
        bus.line_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt != 0) break;
        end
        checks++;
        if (done_cnt == 0) $display("FAIL %s_timeout: done never seen, required within 300 cycles", name);
        else passed++;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        bus.line_start = 1'b0;
        bus.next_line  = 8'd0;
        clear_oam();
        clear_capture();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %0d want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %0d want 0", bus.done); else passed++;
        checks++; if (bus.overflow !== 1'b0) $display("FAIL rst_overflow: got %0d want 0", bus.overflow); else passed++;
        checks++; if (bus.load_valid !== 1'b0) $display("FAIL rst_load_valid: got %0d want 0", bus.load_valid); else passed++;
        checks++; if (bus.oam_addr !== 8'd0) $display("FAIL rst_oam_addr: got %0d want 0", bus.oam_addr); else passed++;
        checks++; if (bus.gfx_addr !== 11'd0) $display("FAIL rst_gfx_addr: got %0d want 0", bus.gfx_addr); else passed++;
        checks++; if (bus.load_data !== 32'd0) $display("FAIL rst_load_data: got %08h want 0", bus.load_data); else passed++;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_hit();
        clear_oam();
        oam_mem[0] = make_ent(9'd100, 8'd10, 7'd5, 1'b0, 1'b1);
        clear_capture();
        start_line(8'd12);
        wait_done("single");
        checks++; if (load_cnt !== 8) $display("FAIL single_loads: got %0d want 8", load_cnt); else passed++;
        checks++; if (done_cyc - start_cyc !== 75) $display("FAIL single_latency: got %0d want 75", done_cyc - start_cyc); else passed++;
        checks++; if (done_cyc - last_load_cyc !== 1) $display("FAIL single_done_gap: got %0d want 1", done_cyc - last_load_cyc); else passed++;
        checks++; if (cap_data[0] !== gfx_val(11'd82)) $display("FAIL single_data0: got %08h want %08h", cap_data[0], gfx_val(11'd82)); else passed++;
        checks++; if (cap_x[0] !== 9'd100) $display("FAIL single_x0: got %0d want 100", cap_x[0]); else passed++;
        checks++; if (cap_pal[0] !== 1'b1) $display("FAIL single_pal0: got %0d want 1", cap_pal[0]); else passed++;
        for (int s = 1; s < 8; s++) begin
            checks++;
            if ({cap_data[s], cap_x[s], cap_pal[s]} !== 42'd0)
                $display("FAIL single_empty_slot%0d: got data=%08h x=%0d pal=%0d want all 0", s, cap_data[s], cap_x[s], cap_pal[s]);
            else passed++;
        end
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (cap_order[s] !== 3'(s)) $display("FAIL single_order%0d: got slot %0d want %0d", s, cap_order[s], s);
            else passed++;
        end
        checks++; if (bus.gfx_addr !== 11'd82) $display("FAIL single_gfx_addr: got %0d want 82", bus.gfx_addr); else passed++;
        checks++; if (bus.overflow !== 1'b0) $display("FAIL single_overflow: got %0d want 0", bus.overflow); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy: got %0d want 0", bus.busy); else passed++;
    endtask

    task automatic test_overflow();
        clear_oam();
        for (int i = 0; i < 9; i++)
            oam_mem[i] = make_ent(9'(10 * i + 1), 8'd20, 7'(i + 1), 1'b0, 1'(i & 1));
        clear_capture();
        start_line(8'd25);
        wait_done("overflow");
        checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %0d want 1", bus.overflow); else passed++;
        checks++; if (bus.oam_addr !== 8'd10) $display("FAIL ovf_scan_stop: oam_addr got %0d want 10", bus.oam_addr); else passed++;
        checks++; if (done_cyc - start_cyc !== 20) $display("FAIL ovf_latency: got %0d want 20", done_cyc - start_cyc); else passed++;
        checks++; if (load_cnt !== 8) $display("FAIL ovf_loads: got %0d want 8", load_cnt); else passed++;
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (cap_data[s] !== gfx_val(11'((s + 1) * 16 + 5)) || cap_x[s] !== 9'(10 * s + 1) || cap_pal[s] !== 1'(s & 1))
                $display("FAIL ovf_slot%0d: got data=%08h x=%0d pal=%0d want data=%08h x=%0d pal=%0d",
                         s, cap_data[s], cap_x[s], cap_pal[s], gfx_val(11'((s + 1) * 16 + 5)), 10 * s + 1, s & 1);
            else passed++;
        end
    endtask

    task automatic test_exact_full();
        clear_oam();
        for (int i = 0; i < 8; i++)
            oam_mem[i] = make_ent(9'(10 * i + 1), 8'd20, 7'(i + 1), 1'b0, 1'(i & 1));
        clear_capture();
        start_line(8'd25);
        wait_done("exact");
        checks++; if (bus.overflow !== 1'b0) $display("FAIL exact_overflow: got %0d want 0", bus.overflow); else passed++;
        checks++; if (done_cyc - start_cyc !== 75) $display("FAIL exact_latency: got %0d want 75", done_cyc - start_cyc); else passed++;
        checks++; if (cap_data[7] !== gfx_val(11'd133)) $display("FAIL exact_data7: got %08h want %08h", cap_data[7], gfx_val(11'd133)); else passed++;
    endtask

    task automatic test_wrap();
        clear_oam();
        oam_mem[0] = make_ent(9'd7, 8'd250, 7'd3, 1'b0, 1'b0);
        clear_capture();
        start_line(8'd3);
        wait_done("wrap_hit");
        checks++; if (cap_data[0] !== gfx_val(11'd57)) $display("FAIL wrap_hit_data: got %08h want %08h", cap_data[0], gfx_val(11'd57)); else passed++;
        checks++; if (cap_x[0] !== 9'd7) $display("FAIL wrap_hit_x: got %0d want 7", cap_x[0]); else passed++;
        oam_mem[0] = make_ent(9'd7, 8'd3, 7'd3, 1'b0, 1'b0);
        clear_capture();
        start_line(8'd2);
        wait_done("wrap_miss");
        checks++; if (load_cnt !== 8) $display("FAIL miss_loads: got %0d want 8", load_cnt); else passed++;
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (cap_data[s] !== 32'd0) $display("FAIL miss_slot%0d: got %08h want 0", s, cap_data[s]);
            else passed++;
        end
        checks++; if (bus.gfx_addr !== 11'd57) $display("FAIL miss_gfx_hold: got %0d want 57", bus.gfx_addr); else passed++;
    endtask

    task automatic test_vflip();
        clear_oam();
        oam_mem[0] = make_ent(9'd200, 8'd50, 7'd2, 1'b1, 1'b0);
        clear_capture();
        start_line(8'd52);
        wait_done("vflip");
        checks++; if (bus.gfx_addr !== 11'd45) $display("FAIL vflip_addr: got %0d want 45", bus.gfx_addr); else passed++;
        checks++; if (cap_data[0] !== gfx_val(11'd45)) $display("FAIL vflip_data: got %08h want %08h", cap_data[0], gfx_val(11'd45)); else passed++;
        checks++; if (cap_x[0] !== 9'd200) $display("FAIL vflip_x: got %0d want 200", cap_x[0]); else passed++;
    endtask

    task automatic test_abort();
        clear_oam();
        oam_mem[0] = make_ent(9'd33, 8'd40, 7'd9, 1'b0, 1'b1);
        clear_capture();
        start_line(8'd39);
        repeat (10) @(posedge clk);
        checks++; if (bus.oam_addr == 8'd0) $display("FAIL abort_precond: oam_addr got 0 want nonzero mid-scan"); else passed++;
        start_line(8'd40);
        checks++; if (bus.oam_addr !== 8'd0) $display("FAIL abort_restart_addr: got %0d want 0", bus.oam_addr); else passed++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL abort_busy: got %0d want 1", bus.busy); else passed++;
        wait_done("abort");
        repeat (20) @(posedge clk);
        #2;
        checks++; if (done_cnt !== 1) $display("FAIL abort_done_count: got %0d want 1", done_cnt); else passed++;
        checks++; if (done_cyc - start_cyc !== 75) $display("FAIL abort_latency: got %0d want 75", done_cyc - start_cyc); else passed++;
        checks++; if (load_cnt !== 8) $display("FAIL abort_loads: got %0d want 8", load_cnt); else passed++;
        checks++; if (cap_data[0] !== gfx_val(11'd144)) $display("FAIL abort_data0: got %08h want %08h", cap_data[0], gfx_val(11'd144)); else passed++;
    endtask

    task automatic test_reset_mid();
        int snap;
        int seen;
        clear_oam();
        for (int i = 0; i < 9; i++)
            oam_mem[i] = make_ent(9'(10 * i + 1), 8'd20, 7'(i + 1), 1'b0, 1'(i & 1));
        clear_capture();
        start_line(8'd25);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (load_cnt >= 4) begin
                seen = 1;
                break;
            end
        end
        checks++; if (seen == 0) $display("FAIL rmid_timeout: slot 3 load never seen, required within 200 cycles"); else passed++;
        checks++; if (bus.load_valid !== 1'b1 || bus.overflow !== 1'b1) $display("FAIL rmid_precond: load_valid=%0d overflow=%0d want 1 1", bus.load_valid, bus.overflow); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (bus.load_valid !== 1'b0) $display("FAIL rmid_load_valid: got %0d want 0", bus.load_valid); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy: got %0d want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL rmid_done: got %0d want 0", bus.done); else passed++;
        checks++; if (bus.overflow !== 1'b0) $display("FAIL rmid_overflow: got %0d want 0", bus.overflow); else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        snap = load_cnt;
        repeat (100) @(posedge clk);
        #2;
        checks++; if (load_cnt !== snap) $display("FAIL rmid_no_loads: got %0d loads after release want 0", load_cnt - snap); else passed++;
        checks++; if (done_cnt !== 0) $display("FAIL rmid_no_done: got %0d want 0", done_cnt); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rmid_idle_busy: got %0d want 0", bus.busy); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_single_hit();
        test_overflow();
        test_exact_full();
        test_wrap();
        test_vflip();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
